// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts PATTERN out MSB-first, repeated
// repeat_cnt+1 times with GAP idle cycles between repetitions.
//
// state  | meaning
// IDLE   | waiting for start; outputs low (done may pulse here)
// SEND   | driving pattern bit bit_idx on outp
// GAP    | idle spacing between repetitions, busy stays high
module sequence_generator #(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 GAP     = 2,
    parameter int                 CNT_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             abort,
    output logic             outp,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(SEQ_LEN);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] bit_idx;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] rep_left;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            bit_idx  <= '0;
            gap_cnt  <= '0;
            rep_left <= '0;
            outp     <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_SEND;
                        rep_left <= repeat_cnt;
                        bit_idx  <= IDX_LAST;
                        outp     <= PATTERN[SEQ_LEN-1];
                        valid    <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        outp  <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (abort) begin
                        state <= S_IDLE;
                        outp  <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else if (bit_idx != '0) begin
                        bit_idx <= bit_idx - IDX_W'(1);
                        outp    <= PATTERN[bit_idx - IDX_W'(1)];
                    end else if (rep_left != '0) begin
                        rep_left <= rep_left - CNT_W'(1);
                        if (GAP > 0) begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_W'(GAP - 1);
                            outp    <= 1'b0;
                            valid   <= 1'b0;
                        end else begin
                            bit_idx <= IDX_LAST;
                            outp    <= PATTERN[SEQ_LEN-1];
                        end
                    end else begin
                        state <= S_IDLE;
                        outp  <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        state <= S_IDLE;
                        outp  <= 1'b0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else if (gap_cnt == '0) begin
                        state   <= S_SEND;
                        bit_idx <= IDX_LAST;
                        outp    <= PATTERN[SEQ_LEN-1];
                        valid   <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    outp  <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
